// File: rtl/frac_logic_ccff_loader.sv
// Configuration-chain loader for one fracturable-logic tile.
// Serialises bitstream words onto ccff_head (MSB first) and can optionally
// verify the load by recirculating a shadow copy of the image through the chain.
module frac_logic_ccff_loader #(
  parameter int unsigned CHAIN_LEN = 21,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = 5
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int unsigned LeftW = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] ChainLenC = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StVerify,
    StDone,
    StError
  } state_e;

  state_e                 state_q, state_d;
  logic                   verify_q, verify_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [CHAIN_LEN-1:0]   shadow_q, shadow_d;
  logic [LeftW-1:0]       bits_left_q, bits_left_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   head_q, head_d;
  logic                   clk_en_q, clk_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [31:0]            remaining;

  // Bits still needed to fill the chain; bounds the bits taken from a word.
  assign remaining = CHAIN_LEN - 32'(cnt_q);

  // Next-state and next-output logic. Registered outputs describe the cycle
  // that follows the edge, so head/clk_en are computed together with state_d.
  always_comb begin
    state_d     = state_q;
    verify_d    = verify_q;
    word_d      = word_q;
    shadow_d    = shadow_q;
    bits_left_d = bits_left_q;
    cnt_d       = cnt_q;
    head_d      = head_q;
    clk_en_d    = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          verify_d = verify_en;
          cnt_d    = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        if (word_valid) begin
          word_d      = word_data;
          bits_left_d = (remaining < WORD_W) ? LeftW'(remaining) : LeftW'(WORD_W);
          head_d      = word_data[WORD_W-1];
          clk_en_d    = 1'b1;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        // head_q is the bit the chain captures at this edge; mirror it into the shadow.
        word_d      = word_q << 1;
        shadow_d    = {shadow_q[CHAIN_LEN-2:0], head_q};
        cnt_d       = cnt_q + 1'b1;
        bits_left_d = bits_left_q - 1'b1;
        if (cnt_d == ChainLenC) begin
          if (verify_q) begin
            cnt_d    = '0;
            head_d   = shadow_d[CHAIN_LEN-1];
            clk_en_d = 1'b1;
            state_d  = StVerify;
          end else begin
            state_d = StDone;
          end
        end else if (bits_left_d == '0) begin
          state_d = StFetch;
        end else begin
          head_d   = word_d[WORD_W-1];
          clk_en_d = 1'b1;
        end
      end
      StVerify: begin
        // The oldest shadow bit is both on ccff_head and expected on ccff_tail.
        if (ccff_tail != shadow_q[CHAIN_LEN-1]) begin
          state_d = StError;
        end else begin
          shadow_d = {shadow_q[CHAIN_LEN-2:0], shadow_q[CHAIN_LEN-1]};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_d == ChainLenC) begin
            state_d = StDone;
          end else begin
            head_d   = shadow_d[CHAIN_LEN-1];
            clk_en_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d  = (state_d == StFetch) || (state_d == StLoad) || (state_d == StVerify);
    done_d  = (state_d == StDone);
    error_d = (state_d == StError);
  end

  // State and registered outputs; reset drops the chain enable immediately.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= StIdle;
      verify_q    <= 1'b0;
      word_q      <= '0;
      shadow_q    <= '0;
      bits_left_q <= '0;
      cnt_q       <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      verify_q    <= verify_d;
      word_q      <= word_d;
      shadow_q    <= shadow_d;
      bits_left_q <= bits_left_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign word_ready  = (state_q == StFetch);
  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign bit_count   = cnt_q;

endmodule
